// File: rtl/iob_sticky_pkg.sv
// Shared constants and helpers for the iob_sticky sticky-bit generator.
// Reset values and the mask-index width used by the thermometer decoder.
package iob_sticky_pkg;

  localparam logic STICKY_RST = 1'b0;
  localparam logic MAN_RST_BIT = 1'b0;
  localparam logic SHIFT_RST_BIT = 1'b0;

  // Width needed to represent every shift value from 0 up to data_w.
  function automatic int mask_idx_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/iob_sticky_mask.sv
// Thermometer decoder: mask bit i is set when i < shift_i.
// Shift amounts at or above DATA_W give an all-ones mask.
module iob_sticky_mask
  import iob_sticky_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHIFT_W = 16
) (
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [DATA_W-1:0]  mask_o
);

  localparam int IDX_W = mask_idx_w(DATA_W);
  localparam int CMP_W = (SHIFT_W > IDX_W) ? SHIFT_W : IDX_W;

  // Full-width unsigned compare, so large shifts saturate instead of aliasing.
  logic [CMP_W-1:0] shift_ext;
  assign shift_ext = CMP_W'(shift_i);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign mask_o[i] = (shift_ext > CMP_W'(i));
  end

endmodule

// File: rtl/iob_sticky.sv
// Registered sticky-bit generator for the rounding path (OR of bits lost on a right shift).
// Define IOB_STICKY_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module iob_sticky
  import iob_sticky_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHIFT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [DATA_W-1:0]  man_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               sticky_o
);

  localparam int LEVELS = $clog2(DATA_W);
  localparam int LEAVES = 1 << LEVELS;

  logic [DATA_W-1:0]  man_s;
  logic [SHIFT_W-1:0] shift_s;
  logic [DATA_W-1:0]  mask;
  logic [DATA_W-1:0]  masked;
  logic [2*LEAVES-2:0] tree;

`ifdef IOB_STICKY_IN_REG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      man_s   <= {DATA_W{MAN_RST_BIT}};
      shift_s <= {SHIFT_W{SHIFT_RST_BIT}};
    end else if (en_i) begin
      man_s   <= man_i;
      shift_s <= shift_i;
    end
  end
`else
  assign man_s   = man_i;
  assign shift_s = shift_i;
`endif

  iob_sticky_mask #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_mask (
    .shift_i (shift_s),
    .mask_o  (mask)
  );

  assign masked = man_s & mask;

  // Heap-ordered OR tree: node n combines nodes 2n+1 and 2n+2; leaves padded with zeros.
  for (genvar l = 0; l < LEAVES; l++) begin : g_leaf
    if (l < DATA_W) begin : g_data
      assign tree[LEAVES-1+l] = masked[l];
    end else begin : g_pad
      assign tree[LEAVES-1+l] = 1'b0;
    end
  end

  for (genvar n = 0; n < LEAVES-1; n++) begin : g_node
    assign tree[n] = tree[2*n+1] | tree[2*n+2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_o <= STICKY_RST;
    end else if (en_i) begin
      sticky_o <= tree[0];
    end
  end

endmodule

// File: tb/tb_iob_sticky.sv
// Directed and random self-checking bench for iob_sticky (DATA_W=32, SHIFT_W=16).
// Latency follows IOB_STICKY_IN_REG_EN.
module tb_iob_sticky;

`ifdef IOB_STICKY_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic [31:0] man_i = 32'h0;
  logic [15:0] shift_i = 16'h0;
  logic        sticky_o;

  int checks = 0;
  int failures = 0;

  iob_sticky #(.DATA_W(32), .SHIFT_W(16)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .man_i    (man_i),
    .shift_i  (shift_i),
    .sticky_o (sticky_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic ref_sticky(input logic [31:0] man, input logic [15:0] sh);
    logic [63:0] m;
    if (sh >= 16'd32) m = 64'hFFFF_FFFF;
    else m = (64'd1 << sh) - 64'd1;
    return |({32'h0, man} & m);
  endfunction

  task automatic check(input string tag, input logic exp);
    checks++;
    assert (sticky_o === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, sticky_o, exp);
    end
  endtask

  // Present one vector, wait the pipeline latency, compare.
  task automatic vec(input string tag, input logic [31:0] man, input logic [15:0] sh, input logic exp);
    man_i = man;
    shift_i = sh;
    repeat (LAT) @(posedge clk_i);
    #1;
    check(tag, exp);
  endtask

  logic exp_q[$];

  initial begin
    man_i = 32'ha2e513cd;
    shift_i = 16'd5;
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      check("reset_hold", 1'b0);
    end
    rst_i = 1'b0;

    vec("cd_s0",  32'ha2e513cd, 16'd0,  1'b0);
    vec("cd_s1",  32'ha2e513cd, 16'd1,  1'b1);
    vec("cd_s5",  32'ha2e513cd, 16'd5,  1'b1);
    vec("cd_s30", 32'ha2e513cd, 16'd30, 1'b1);

    vec("00_s0",  32'ha2e51300, 16'd0,  1'b0);
    vec("00_s5",  32'ha2e51300, 16'd5,  1'b0);
    vec("00_s8",  32'ha2e51300, 16'd8,  1'b0);
    vec("00_s9",  32'ha2e51300, 16'd9,  1'b1);
    vec("00_s30", 32'ha2e51300, 16'd30, 1'b1);

    vec("sat_s31",  32'h80000000, 16'd31,    1'b0);
    vec("sat_s32",  32'h80000000, 16'd32,    1'b1);
    vec("sat_ffff", 32'h80000000, 16'hFFFF,  1'b1);
    vec("zero_ffff", 32'h0,       16'hFFFF,  1'b0);
    vec("sat_s256", 32'h00000001, 16'd256,   1'b1);

    vec("en_pre", 32'ha2e51300, 16'd5, 1'b0);
    en_i = 1'b0;
    man_i = 32'ha2e513cd;
    shift_i = 16'd5;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk_i);
      #1;
      check("en_low_hold", 1'b0);
    end
    en_i = 1'b1;
    repeat (LAT) @(posedge clk_i);
    #1;
    check("en_high", 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_mid", 1'b0);
    @(posedge clk_i);
    #1;
    check("rst_hold", 1'b0);
    rst_i = 1'b0;

    // Back-to-back random stream, one new vector per cycle.
    for (int n = 0; n < 10000 + LAT; n++) begin
      logic [31:0] m;
      logic [15:0] s;
      if (n < 10000) begin
        m = $urandom;
        if ((n % 4) == 1) m = m & $urandom & $urandom & $urandom;
        if ((n % 8) == 3) m = 32'h1 << $urandom_range(31, 0);
        if ((n % 64) == 7) m = 32'h0;
        s = ((n % 5) == 0) ? 16'($urandom) : 16'($urandom_range(40, 0));
      end else begin
        m = 32'h0;
        s = 16'h0;
      end
      man_i = m;
      shift_i = s;
      exp_q.push_back(ref_sticky(m, s));
      @(posedge clk_i);
      #1;
      if (exp_q.size() == LAT) check("random", exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
